lockstep_voter: RTL and testbench
=================================

// Module: lockstep_voter
// PURPOSE
//  Parametrised successor of the DMR OBI request checker; sits between the lockstep harts and the bus crossbar.
//  Compares instr/data OBI requests of NHARTS cores: DMR detect-and-gate, or TMR majority vote with faulty-hart isolation.
//  Sequential fault FSM (RUN/DEGRADED/HALT), sticky fault mask, saturating correctable-error counter, SW-driven recovery.
// PARAMETERS
//  NHARTS   3  number of lockstep harts, legal 2..3; with 2, MODE_TMR behaves as MODE_DMR
//  CNT_W    8  width of correctable-error counter
// PORTS
//  clk_i                 in   1              clock
//  rst_ni                in   1              async active-low reset
//  mode_i                in   2              lockstep_mode_e; sampled only at reset release and on recover_i
//  recover_i             in   1              SW resync done: clear fault mask, return to RUN (1-cycle pulse)
//  core_instr_req_i      in   NHARTS x obi_req_t  per-hart instr requests
//  core_data_req_i       in   NHARTS x obi_req_t  per-hart data requests
//  voted_instr_req_o     out  obi_req_t      instr request forwarded to bus
//  voted_data_req_o      out  obi_req_t      data request forwarded to bus
//  halt_o                out  1              state==HALT (outputs gated)
//  fault_mask_o          out  NHARTS         sticky per-hart isolated-fault flags
//  err_corr_o            out  1              1-cycle pulse: mismatch outvoted (TMR)
//  err_uncorr_o          out  1              1-cycle pulse: no majority; entering HALT
//  corr_cnt_o            out  CNT_W          saturating count of err_corr_o pulses
// BEHAVIOUR
//  Reset: state=RUN, mode_q=mode_i, fault_mask=0, corr_cnt=0, pulses 0; voted_* follow comb rules below.
//  Request equality per pair: req must match; if both req=1 also addr, we, be; wdata only if we=1. req=0 on both => equal.
//  Equality evaluated on instr and data bus independently; a hart disagrees if it disagrees on either bus.
//  MODE_OFF: voted_* = hart 0, no checking, no state changes except recover_i.
//  MODE_DMR: hart0!=hart1 -> voted_*='0 same cycle, err_uncorr_o, next state HALT.
//  MODE_TMR, RUN: all equal -> hart 0 forwarded. Exactly one hart k differs -> forward majority value same cycle,
//   set fault_mask[k], err_corr_o=1, corr_cnt+=1 (saturate at all-ones), next DEGRADED. All three differ -> gate '0, HALT.
//  DEGRADED: compare the two healthy harts only (DMR rules); forward lowest-index healthy hart; mismatch -> HALT.
//  HALT: voted_*='0 every cycle; no further pulses or counting; hold until recover_i.
//  recover_i: next RUN, fault_mask=0, mode_q=mode_i; corr_cnt preserved. Latency 1 cycle.
//  recover_i and a new mismatch same cycle: mismatch wins (HALT / DEGRADED as above), mode_q still reloads.
//  Output path purely combinational (0 cycle latency, gnt/rvalid untouched); gating never lets a mismatching req through.
//  Async reset mid-transaction: all state cleared immediately; a pending bus request is dropped.
//  Illegal mode encoding -> treated as MODE_DMR.
// STRUCTURE
//  cei_mochila_pkg: lockstep_mode_e {MODE_OFF,MODE_DMR,MODE_TMR}, lockstep_state_e {LS_RUN,LS_DEGRADED,LS_HALT}.
//  Sub-module lockstep_req_cmp: masked equality of two obi_req_t, instantiated per hart pair per bus.
//  Top holds the vote/select mux, FSM, fault mask and counter registers.
// TESTING
//  TMR, identical reqs addr=0x1000 -> voted=hart0, no pulses, state RUN, corr_cnt=0.
//  TMR, hart2 data addr=0x2004 vs 0x2000 -> voted addr=0x2000, err_corr_o 1 cycle, fault_mask=3'b100, cnt=1, DEGRADED.
//  DEGRADED then hart0 wdata differs (we=1) -> voted='0 same cycle, err_uncorr_o, halt_o=1 until recover_i.
//  DMR, be 4'hF vs 4'h3 with req=1 -> gated '0, HALT; recover_i -> RUN, mask 0, cnt unchanged.
//  Mismatch only in wdata with we=0, or in addr with req=0 on both harts -> no error.
//  260 correctable events with CNT_W=8 -> corr_cnt_o saturates at 0xFF; rst_ni low mid-HALT -> RUN, cnt=0.

Source files
------------

// File: rtl/cei_mochila_pkg.sv
// Shared types for the lockstep request voter: OBI request, lockstep mode and fault state.
package cei_mochila_pkg;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_DMR = 2'd1,
    MODE_TMR = 2'd2
  } lockstep_mode_e;

  typedef enum logic [1:0] {
    LS_RUN      = 2'd0,
    LS_DEGRADED = 2'd1,
    LS_HALT     = 2'd2
  } lockstep_state_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  // Illegal encodings fall back to DMR; TMR needs a third hart to vote with.
  function automatic lockstep_mode_e decode_mode(input logic [1:0] raw, input int nharts);
    case (raw)
      2'd0:    return MODE_OFF;
      2'd2:    return (nharts >= 3) ? MODE_TMR : MODE_DMR;
      default: return MODE_DMR;
    endcase
  endfunction

endpackage

// File: rtl/lockstep_req_cmp.sv
// Masked equality of two OBI requests; fields only matter when the request is live.
module lockstep_req_cmp
  import cei_mochila_pkg::*;
(
  input  obi_req_t i_a,
  input  obi_req_t i_b,
  output logic     o_eq
);

  logic w_hdr_eq;
  logic w_wdata_eq;

  assign w_hdr_eq   = (i_a.addr == i_b.addr) && (i_a.we == i_b.we) && (i_a.be == i_b.be);
  assign w_wdata_eq = !i_a.we || (i_a.wdata == i_b.wdata);
  assign o_eq       = (i_a.req == i_b.req) && (!i_a.req || (w_hdr_eq && w_wdata_eq));

endmodule

// File: rtl/lockstep_voter.sv
// Lockstep OBI request voter: DMR gate or TMR majority vote with fault isolation and recovery.
module lockstep_voter
  import cei_mochila_pkg::*;
#(
  parameter int NHARTS = 3,
  parameter int CNT_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              mode_i,
  input  logic                    recover_i,
  input  obi_req_t [NHARTS-1:0]   core_instr_req_i,
  input  obi_req_t [NHARTS-1:0]   core_data_req_i,
  output obi_req_t                voted_instr_req_o,
  output obi_req_t                voted_data_req_o,
  output logic                    halt_o,
  output logic [NHARTS-1:0]       fault_mask_o,
  output logic                    err_corr_o,
  output logic                    err_uncorr_o,
  output logic [CNT_W-1:0]        corr_cnt_o
);

  localparam int NPAIRS = (NHARTS >= 3) ? 3 : 1;

  lockstep_state_e r_state, w_next_state;
  lockstep_mode_e  r_mode, w_mode, w_next_mode;
  logic            r_loaded;
  logic [2:0]      r_mask, w_next_mask;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;

  // Pair index: 0 = harts 0/1, 1 = harts 0/2, 2 = harts 1/2.
  logic [2:0] w_pair_eq;
  logic [1:0] w_sel;
  logic       w_gate, w_corr, w_uncorr;
  logic [2:0] w_bad;

  for (genvar p = 0; p < 3; p++) begin : g_pair
    if (p < NPAIRS) begin : g_cmp
      localparam int A = (p == 2) ? 1 : 0;
      localparam int B = (p == 0) ? 1 : 2;
      logic w_i_eq, w_d_eq;
      lockstep_req_cmp u_cmp_instr (.i_a(core_instr_req_i[A]), .i_b(core_instr_req_i[B]), .o_eq(w_i_eq));
      lockstep_req_cmp u_cmp_data  (.i_a(core_data_req_i[A]),  .i_b(core_data_req_i[B]),  .o_eq(w_d_eq));
      assign w_pair_eq[p] = w_i_eq & w_d_eq;
    end else begin : g_tie
      assign w_pair_eq[p] = 1'b1;
    end
  end

  // Until the first clock after reset the mode register is not loaded yet; use the live input.
  assign w_mode = r_loaded ? r_mode : decode_mode(mode_i, NHARTS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= LS_RUN;
      r_mode   <= MODE_DMR;
      r_loaded <= 1'b0;
      r_mask   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next_state;
      r_mode   <= w_next_mode;
      r_loaded <= 1'b1;
      r_mask   <= w_next_mask;
      r_cnt    <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = recover_i ? LS_RUN : r_state;
    w_next_mask  = recover_i ? 3'b000 : r_mask;
    w_next_mode  = (recover_i || !r_loaded) ? decode_mode(mode_i, NHARTS) : r_mode;
    w_next_cnt   = r_cnt;
    if (w_uncorr) begin
      w_next_state = LS_HALT;
    end else if (w_corr) begin
      w_next_state = LS_DEGRADED;
      w_next_mask  = w_next_mask | w_bad;
      if (r_cnt != {CNT_W{1'b1}}) w_next_cnt = r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_sel    = 2'd0;
    w_gate   = 1'b0;
    w_corr   = 1'b0;
    w_uncorr = 1'b0;
    w_bad    = 3'b000;
    if (r_state == LS_HALT) begin
      w_gate = 1'b1;
    end else if (w_mode == MODE_OFF) begin
      w_sel = 2'd0;
    end else if (r_state == LS_DEGRADED) begin
      // Only the two harts still trusted take part; forward the lower-indexed one.
      if (r_mask[0]) begin
        w_sel    = 2'd1;
        w_uncorr = !w_pair_eq[2];
      end else if (r_mask[1]) begin
        w_uncorr = !w_pair_eq[1];
      end else begin
        w_uncorr = !w_pair_eq[0];
      end
      w_gate = w_uncorr;
    end else if (w_mode == MODE_DMR) begin
      w_uncorr = !w_pair_eq[0];
      w_gate   = w_uncorr;
    end else if (w_pair_eq == 3'b111) begin
      w_sel = 2'd0;
    end else if (w_pair_eq == 3'b001) begin
      w_corr = 1'b1;
      w_bad  = 3'b100;
    end else if (w_pair_eq == 3'b010) begin
      w_corr = 1'b1;
      w_bad  = 3'b010;
    end else if (w_pair_eq == 3'b100) begin
      w_corr = 1'b1;
      w_bad  = 3'b001;
      w_sel  = 2'd1;
    end else begin
      w_uncorr = 1'b1;
      w_gate   = 1'b1;
    end
  end

  assign voted_instr_req_o = w_gate ? '0 : core_instr_req_i[w_sel];
  assign voted_data_req_o  = w_gate ? '0 : core_data_req_i[w_sel];
  assign halt_o            = (r_state == LS_HALT);
  assign fault_mask_o      = r_mask[NHARTS-1:0];
  assign err_corr_o        = w_corr;
  assign err_uncorr_o      = w_uncorr;
  assign corr_cnt_o        = r_cnt;

endmodule

// File: tb/tb_lockstep_voter.sv
// Self-checking bench for lockstep_voter: vector table, corner sequences and randomized model comparison.
module tb_lockstep_voter;
  import cei_mochila_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [1:0] mode_i = 2'd2;
  logic recover_i = 1'b0;
  obi_req_t [2:0] ireq, dreq;
  obi_req_t voted_instr, voted_data;
  logic halt, err_corr, err_uncorr;
  logic [2:0] fault_mask;
  logic [7:0] corr_cnt;

  always #5 clk = ~clk;

  lockstep_voter #(.NHARTS(3), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .mode_i(mode_i), .recover_i(recover_i),
    .core_instr_req_i(ireq), .core_data_req_i(dreq),
    .voted_instr_req_o(voted_instr), .voted_data_req_o(voted_data),
    .halt_o(halt), .fault_mask_o(fault_mask), .err_corr_o(err_corr),
    .err_uncorr_o(err_uncorr), .corr_cnt_o(corr_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: state 0=RUN 1=DEGRADED 2=HALT, mode 0=OFF 1=DMR 2=TMR.
  int m_state, m_mode, m_cnt, n_state, n_mode, n_cnt;
  bit [2:0] m_mask, n_mask;
  obi_req_t e_ivote, e_dvote;
  bit e_corr, e_unc;

  function automatic bit req_eq(input obi_req_t a, input obi_req_t b);
    if (a.req != b.req) return 0;
    if (!a.req) return 1;
    if (a.addr != b.addr || a.we != b.we || a.be != b.be) return 0;
    if (a.we && a.wdata != b.wdata) return 0;
    return 1;
  endfunction

  function automatic int dec_mode(input logic [1:0] raw);
    if (raw == 2'd0) return 0;
    if (raw == 2'd2) return 2;
    return 1;
  endfunction

  task automatic model_eval;
    int parts[$];
    int agree[3];
    int lonely, paired, lone_h, fwd;
    bit all_ok;
    e_ivote = ireq[0]; e_dvote = dreq[0]; e_corr = 0; e_unc = 0;
    n_state = recover_i ? 0 : m_state;
    n_mask  = recover_i ? 3'b000 : m_mask;
    n_mode  = recover_i ? dec_mode(mode_i) : m_mode;
    n_cnt   = m_cnt;
    if (m_state == 2) begin
      e_ivote = '0; e_dvote = '0;
    end else if (m_mode != 0) begin
      if (m_state == 1) begin
        for (int i = 0; i < 3; i++) if (!m_mask[i]) parts.push_back(i);
      end else if (m_mode == 1) parts = '{0, 1};
      else parts = '{0, 1, 2};
      all_ok = 1; lonely = 0; paired = 0; lone_h = 0; fwd = -1;
      foreach (parts[x]) begin
        agree[parts[x]] = 0;
        foreach (parts[y])
          if (x != y && req_eq(ireq[parts[x]], ireq[parts[y]]) && req_eq(dreq[parts[x]], dreq[parts[y]]))
            agree[parts[x]]++;
        if (agree[parts[x]] != parts.size() - 1) all_ok = 0;
        if (agree[parts[x]] == 0) begin lonely++; lone_h = parts[x]; end
        if (agree[parts[x]] == 1) begin paired++; if (fwd < 0) fwd = parts[x]; end
      end
      if (all_ok) begin
        e_ivote = ireq[parts[0]]; e_dvote = dreq[parts[0]];
      end else if (parts.size() == 3 && lonely == 1 && paired == 2) begin
        e_corr = 1; e_ivote = ireq[fwd]; e_dvote = dreq[fwd];
        n_state = 1; n_mask[lone_h] = 1'b1;
        if (n_cnt < 255) n_cnt++;
      end else begin
        e_unc = 1; e_ivote = '0; e_dvote = '0; n_state = 2;
      end
    end
  endtask

  task automatic cycle(input string tag);
    #2;
    model_eval();
    chk({tag, " voted_instr"}, voted_instr, e_ivote);
    chk({tag, " voted_data"}, voted_data, e_dvote);
    chk({tag, " err_corr/err_uncorr"}, {err_corr, err_uncorr}, {e_corr, e_unc});
    chk({tag, " halt/mask/cnt"}, {halt, fault_mask, corr_cnt}, {m_state == 2, m_mask, 8'(m_cnt)});
    @(posedge clk);
    m_state = n_state; m_mask = n_mask; m_mode = n_mode; m_cnt = n_cnt;
    @(negedge clk);
  endtask

  obi_req_t idle;

  task automatic do_reset(input logic [1:0] mode);
    @(negedge clk);
    rst_ni = 1'b0; mode_i = mode; recover_i = 1'b0;
    ireq = {idle, idle, idle}; dreq = {idle, idle, idle};
    #2;
    chk("reset state", {halt, fault_mask, corr_cnt, err_corr, err_uncorr}, '0);
    m_state = 0; m_mask = 0; m_cnt = 0; m_mode = dec_mode(mode);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic [1:0] mode;
    obi_req_t   d[3];
    int         sel;
    bit         corr, unc;
    bit [2:0]   mask;
  } vec_t;

  function automatic vec_t mkv(input logic [1:0] mode, input obi_req_t a, input obi_req_t b, input obi_req_t c,
                               input int sel, input bit corr, input bit unc, input bit [2:0] mask);
    vec_t v;
    v.mode = mode; v.d[0] = a; v.d[1] = b; v.d[2] = c;
    v.sel = sel; v.corr = corr; v.unc = unc; v.mask = mask;
    return v;
  endfunction

  initial begin
    vec_t tab[$];
    obi_req_t b, x, y, bb, nr, ro, rw, i0, i1, ba, bw;
    obi_req_t exp_v;
    idle = '0;
    b  = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h1000, wdata: 32'hCAFE_F00D};
    x  = b; x.addr = 32'h1004;
    y  = b; y.wdata = 32'hDEAD_BEEF;
    bb = b; bb.be = 4'h3;
    nr = b; nr.req = 1'b0;
    ro = b; ro.we = 1'b0;
    rw = ro; rw.wdata = 32'h1234_5678;
    i0 = '0; i0.addr = 32'h1000;
    i1 = i0; i1.addr = 32'h5555_0000;
    tab.push_back(mkv(2'd2, b, b, b, 0, 0, 0, 3'b000));
    tab.push_back(mkv(2'd2, b, b, x, 0, 1, 0, 3'b100));
    tab.push_back(mkv(2'd2, x, b, b, 1, 1, 0, 3'b001));
    tab.push_back(mkv(2'd2, b, nr, b, 0, 1, 0, 3'b010));
    tab.push_back(mkv(2'd2, b, x, y, -1, 0, 1, 3'b000));
    tab.push_back(mkv(2'd1, b, bb, b, -1, 0, 1, 3'b000));
    tab.push_back(mkv(2'd1, ro, rw, ro, 0, 0, 0, 3'b000));
    tab.push_back(mkv(2'd1, i0, i1, i0, 0, 0, 0, 3'b000));
    tab.push_back(mkv(2'd0, b, x, y, 0, 0, 0, 3'b000));
    tab.push_back(mkv(2'd3, b, x, b, -1, 0, 1, 3'b000));
    tab.push_back(mkv(2'd1, b, b, x, 0, 0, 0, 3'b000));

    foreach (tab[i]) begin
      do_reset(tab[i].mode);
      dreq = {tab[i].d[2], tab[i].d[1], tab[i].d[0]};
      #2;
      exp_v = (tab[i].sel < 0) ? '0 : tab[i].d[tab[i].sel];
      chk($sformatf("tab%0d voted_data", i), voted_data, exp_v);
      chk($sformatf("tab%0d pulses", i), {err_corr, err_uncorr}, {tab[i].corr, tab[i].unc});
      #1;
      cycle($sformatf("tab%0d", i));
      #1;
      chk($sformatf("tab%0d mask/halt", i), {fault_mask, halt}, {tab[i].mask, tab[i].unc});
    end

    // TMR correct -> DEGRADED -> uncorrectable -> HALT -> recover.
    do_reset(2'd2);
    ba = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h2000, wdata: 32'h0};
    x = ba; x.addr = 32'h2004;
    dreq = {x, ba, ba};
    #2;
    chk("seqA corr addr", voted_data.addr, 32'h2000);
    chk("seqA corr pulse", {err_corr, err_uncorr}, 2'b10);
    #1;
    cycle("seqA1");
    chk("seqA degraded mask/cnt", {fault_mask, corr_cnt, halt}, {3'b100, 8'd1, 1'b0});
    bw = ba; bw.we = 1'b1; bw.wdata = 32'hAAAA_5555;
    y = bw; y.wdata = 32'hAAAA_5554;
    dreq = {bw, bw, y};
    #2;
    chk("seqA gated", voted_data, '0);
    chk("seqA uncorr pulse", {err_corr, err_uncorr}, 2'b01);
    #1;
    cycle("seqA2");
    dreq = {bw, bw, bw};
    for (int k = 0; k < 3; k++) begin
      cycle("seqA halt");
      chk("seqA halt held", {halt, err_uncorr, voted_data}, {1'b1, 1'b0, 70'h0});
    end
    recover_i = 1'b1;
    cycle("seqA recover");
    recover_i = 1'b0;
    #1;
    chk("seqA after recover", {halt, fault_mask, corr_cnt}, {1'b0, 3'b000, 8'd1});
    #1;
    @(negedge clk);

    // Counter saturation, then async reset in the middle of HALT.
    do_reset(2'd2);
    for (int k = 0; k < 260; k++) begin
      x = b; x.addr = 32'h3000 + k;
      dreq = {b, x, b};
      cycle("sat corr");
      dreq = {b, b, b};
      recover_i = 1'b1;
      cycle("sat recover");
      recover_i = 1'b0;
    end
    chk("sat count", corr_cnt, 8'hFF);
    x = b; x.addr = 32'h4000;
    y = b; y.addr = 32'h5000;
    dreq = {y, x, b};
    cycle("sat halt");
    chk("sat in halt", halt, 1'b1);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("async reset mid-halt", {halt, fault_mask, corr_cnt}, '0);
    m_state = 0; m_mask = 0; m_cnt = 0; m_mode = dec_mode(mode_i);
    dreq = {idle, idle, idle};
    @(negedge clk);
    rst_ni = 1'b1;
    cycle("post reset");

    // Randomized traffic compared cycle by cycle to the reference model.
    for (int n = 0; n < 3000; n++) begin
      obi_req_t ri, rd;
      ri = '{req: ($urandom_range(3) != 0), we: 1'b0, be: 4'hF, addr: {$urandom_range(3), 2'b00}, wdata: 32'h0};
      rd = '{req: ($urandom_range(3) != 0), we: $urandom_range(1), be: 4'($urandom),
             addr: {$urandom_range(7), 2'b00}, wdata: $urandom_range(3)};
      ireq = {ri, ri, ri};
      dreq = {rd, rd, rd};
      for (int h = 0; h < 3; h++) begin
        if ($urandom_range(11) == 0) ireq[h].addr ^= 32'h10;
        case ($urandom_range(15))
          0: dreq[h].req   = ~dreq[h].req;
          1: dreq[h].addr  ^= 32'h100;
          2: dreq[h].we    = ~dreq[h].we;
          3: dreq[h].be    ^= 4'h1;
          4, 5: dreq[h].wdata ^= 32'h8000_0000;
          default: ;
        endcase
      end
      recover_i = ($urandom_range(9) == 0);
      mode_i = 2'($urandom);
      cycle("rnd");
    end
    recover_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
